alu_cpu: RTL and testbench
==========================

Name: alu_cpu

Overview:
- 8-bit accumulator-style microprocessor core that the top level instantiates under the module name ALU.
- Fetches instructions from an external synchronous 256x8 ROM.
- Reads and writes memory-mapped RAM and peripherals over a shared tri-state 8-bit data bus with an 8-bit address.
- Services two interrupt lines, which it acknowledges.

Parameters:
- ISR_VEC0_ADDR, 8'hFF: ROM location holding the interrupt-0 service address.
- ISR_VEC1_ADDR, 8'hFE: ROM location holding the interrupt-1 service address.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RESET  input  1  asynchronous, active-low reset.
- BUS_DATA  inout  8  shared data bus; driven with the write value only while BUS_WE=1, otherwise high-Z.
- BUS_ADDR  output  8  bus address.
- BUS_WE  output  1  bus write enable.
- ROM_ADDRESS  output  8  instruction ROM address.
- ROM_DATA  input  8  ROM byte, valid one cycle after ROM_ADDRESS changes.
- BUS_INTERRUPTS_RAISE  input  2  interrupt requests, level-sensitive.
- BUS_INTERRUPTS_ACK  output  2  one-cycle acknowledge pulse per serviced interrupt.

Behaviour:
- Reset (RESET=0, asynchronous):
  - Registers: PC=0, A=0, B=0, return register=0, BUS_WE=0, BUS_ADDR=8'hFF, BUS_DATA released, ROM_ADDRESS=0, ACK=2'b00.
  - State = FETCH.
  - Reset asserted mid-instruction aborts it immediately; no bus write completes afterwards.
- Instruction fetch:
  - FETCH drives ROM_ADDRESS=PC.
  - FETCH_WAIT waits one cycle.
  - DECODE latches ROM_DATA as the opcode.
  - Operand byte, where present, is fetched the same way from PC+1.
  - PC is 8 bits and wraps FF->00.
- Opcode low nibble (unlisted codes behave as NOP, PC+1):
  - 0: A<=mem[op].
  - 1: B<=mem[op].
  - 2: mem[op]<=A.
  - 3: mem[op]<=B.
  - 4: A<=ALU(hi nibble).
  - 5: B<=ALU(hi nibble).
  - 6: branch to op if ALU(hi nibble)[0]==1.
  - 7: goto op.
  - 8: IDLE.
  - 9: call op, return register<=PC+2.
  - A: return, PC<=return register.
  - B: A<=mem[A].
  - C: B<=mem[B].
  - Two-byte instructions are 0,1,2,3,6,7,9; all others are one byte.
- ALU (combinational, 8-bit, results truncated mod 256, no flags), selected by opcode high nibble:
  - 0: A+B.
  - 1: A-B.
  - 2: A*B low byte.
  - 3: A<<1.
  - 4: A>>1 (logical).
  - 5: A+1.
  - 6: B+1.
  - 7: A-1.
  - 8: B-1.
  - 9: A==B.
  - A: A>B unsigned.
  - B: A<B unsigned.
  - C-F: A.
  - Compare ops yield 8'h01 or 8'h00.
- Memory read:
  - BUS_ADDR<=addr with BUS_WE=0.
  - Wait two cycles.
  - Latch BUS_DATA into the target register in the third cycle.
- Memory write:
  - BUS_ADDR<=addr, BUS_WE=1 and BUS_DATA driven for exactly one cycle.
  - Then BUS_WE=0 and BUS_DATA is released.
- Interrupts:
  - Sampled only at an instruction boundary (entering FETCH) or while in IDLE.
  - If both lines are raised, bit 0 has priority.
  - Servicing interrupt n:
    - Pulse ACK[n] high for one cycle.
    - Return register<=address of the next instruction.
    - Read the vector byte from ROM at ISR_VECn_ADDR.
    - PC<=vector, then FETCH.
  - No interrupts are taken while an ISR is running; an ISR ends with opcode A (return), which re-enables interrupts.
  - Nested calls are unsupported: a single return register.
- IDLE: no bus activity and BUS_WE=0; leaves IDLE only via an interrupt.

Test Plan:
- Reset: hold RESET=0 50 ns, release -> ROM_ADDRESS=00, BUS_WE=0, ACK=00, BUS_DATA high-Z; first opcode fetched from 00.
- ROM fetch: ROM at 00 = 8'h00, 01 = 8'h0F, bench bus returns 8'hE5 for address 0F -> BUS_ADDR=0F, A=E5 after the read completes.
- Write/ALU: A=E5, B=1B, opcode 8'h04 (add) then 8'h02 with operand 8'h20 -> one-cycle BUS_WE with BUS_ADDR=20, BUS_DATA=00 (E5+1B wraps).
- Branch edge: A=05, B=05, opcode 8'h96 with operand 8'hFF -> PC=FF; executing at FF wraps the next fetch to 00.
- Interrupt: program at IDLE, raise RAISE=2'b11 with ROM[FF]=8'h40 -> ACK=01 for one cycle, next ROM_ADDRESS=40; return opcode 8'h0A resumes after IDLE, then interrupt 1 is serviced via ROM[FE].
- Reset mid-write: assert RESET during the BUS_WE=1 cycle -> BUS_WE drops immediately and BUS_DATA is released.

Source files
------------

// File: rtl/alu_cpu.sv
// alu_cpu: 8-bit accumulator-style processor core.
// Fetches from a synchronous 256x8 ROM, accesses memory-mapped RAM and
// peripherals over a shared tri-state bus, and services two interrupt lines.
`timescale 1ns/1ps

module alu_cpu #(
    parameter logic [7:0] ISR_VEC0_ADDR = 8'hFF,
    parameter logic [7:0] ISR_VEC1_ADDR = 8'hFE
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    output logic [7:0] BUS_ADDR,
    output logic       BUS_WE,
    output logic [7:0] ROM_ADDRESS,
    input  logic [7:0] ROM_DATA,
    input  logic [1:0] BUS_INTERRUPTS_RAISE,
    output logic [1:0] BUS_INTERRUPTS_ACK
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_FETCH_WAIT,
        S_DECODE,
        S_OPER_WAIT,
        S_OPER_EXEC,
        S_READ_0,
        S_READ_1,
        S_READ_2,
        S_WRITE,
        S_IDLE,
        S_INT_WAIT,
        S_INT_LATCH
    } state_t;

    state_t     state, state_n;
    logic [7:0] pc, pc_n;
    logic [7:0] a, a_n;
    logic [7:0] b, b_n;
    logic [7:0] ret, ret_n;
    logic [7:0] opcode, opcode_n;
    logic [7:0] wdata, wdata_n;
    logic [7:0] bus_addr_n;
    logic [7:0] rom_addr_n;
    logic [1:0] ack_n;
    logic       bus_we_n;
    logic       int_en, int_en_n;
    logic       read_b, read_b_n;
    logic [3:0] alu_sel;
    logic [7:0] alu_res;
    logic       irq_take;

    // Combinational ALU; results wrap mod 256, compares give 8'h01 / 8'h00.
    function automatic logic [7:0] alu_op(input logic [3:0] sel,
                                          input logic [7:0] x,
                                          input logic [7:0] y);
        logic [7:0] r;
        case (sel)
            4'h0:    r = x + y;
            4'h1:    r = x - y;
            4'h2:    r = x * y;
            4'h3:    r = {x[6:0], 1'b0};
            4'h4:    r = {1'b0, x[7:1]};
            4'h5:    r = x + 8'd1;
            4'h6:    r = y + 8'd1;
            4'h7:    r = x - 8'd1;
            4'h8:    r = y - 8'd1;
            4'h9:    r = {7'd0, x == y};
            4'hA:    r = {7'd0, x > y};
            4'hB:    r = {7'd0, x < y};
            default: r = x;
        endcase
        return r;
    endfunction

    // During DECODE the opcode is still on ROM_DATA; later states use the latched copy.
    assign alu_sel  = (state == S_DECODE) ? ROM_DATA[7:4] : opcode[7:4];
    assign alu_res  = alu_op(alu_sel, a, b);
    assign irq_take = int_en & (|BUS_INTERRUPTS_RAISE);
    assign BUS_DATA = BUS_WE ? wdata : 8'hzz;

    // State and register update; reset aborts any instruction and releases the bus.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state              <= S_FETCH;
            pc                 <= 8'h00;
            a                  <= 8'h00;
            b                  <= 8'h00;
            ret                <= 8'h00;
            opcode             <= 8'h00;
            wdata              <= 8'h00;
            BUS_ADDR           <= 8'hFF;
            BUS_WE             <= 1'b0;
            ROM_ADDRESS        <= 8'h00;
            BUS_INTERRUPTS_ACK <= 2'b00;
            int_en             <= 1'b1;
            read_b             <= 1'b0;
        end else begin
            state              <= state_n;
            pc                 <= pc_n;
            a                  <= a_n;
            b                  <= b_n;
            ret                <= ret_n;
            opcode             <= opcode_n;
            wdata              <= wdata_n;
            BUS_ADDR           <= bus_addr_n;
            BUS_WE             <= bus_we_n;
            ROM_ADDRESS        <= rom_addr_n;
            BUS_INTERRUPTS_ACK <= ack_n;
            int_en             <= int_en_n;
            read_b             <= read_b_n;
        end
    end

    // Next-state and datapath decisions; write enable and ACK default low so each is a single-cycle pulse.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        a_n        = a;
        b_n        = b;
        ret_n      = ret;
        opcode_n   = opcode;
        wdata_n    = wdata;
        bus_addr_n = BUS_ADDR;
        bus_we_n   = 1'b0;
        rom_addr_n = ROM_ADDRESS;
        ack_n      = 2'b00;
        int_en_n   = int_en;
        read_b_n   = read_b;
        case (state)
            S_FETCH, S_IDLE: begin
                if (irq_take) begin
                    // Line 0 wins when both are raised; pc already points at the next instruction.
                    ack_n      = BUS_INTERRUPTS_RAISE[0] ? 2'b01 : 2'b10;
                    rom_addr_n = BUS_INTERRUPTS_RAISE[0] ? ISR_VEC0_ADDR : ISR_VEC1_ADDR;
                    ret_n      = pc;
                    int_en_n   = 1'b0;
                    state_n    = S_INT_WAIT;
                end else if (state == S_FETCH) begin
                    rom_addr_n = pc;
                    state_n    = S_FETCH_WAIT;
                end
            end
            S_FETCH_WAIT: state_n = S_DECODE;
            S_DECODE: begin
                opcode_n = ROM_DATA;
                pc_n     = pc + 8'd1;
                state_n  = S_FETCH;
                case (ROM_DATA[3:0])
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h9: begin
                        pc_n       = pc;
                        rom_addr_n = pc + 8'd1;
                        state_n    = S_OPER_WAIT;
                    end
                    4'h4: a_n = alu_res;
                    4'h5: b_n = alu_res;
                    4'h8: state_n = S_IDLE;
                    4'hA: begin
                        pc_n     = ret;
                        int_en_n = 1'b1;
                    end
                    4'hB: begin
                        bus_addr_n = a;
                        read_b_n   = 1'b0;
                        state_n    = S_READ_0;
                    end
                    4'hC: begin
                        bus_addr_n = b;
                        read_b_n   = 1'b1;
                        state_n    = S_READ_0;
                    end
                    default: ;
                endcase
            end
            S_OPER_WAIT: state_n = S_OPER_EXEC;
            S_OPER_EXEC: begin
                pc_n    = pc + 8'd2;
                state_n = S_FETCH;
                case (opcode[3:0])
                    4'h0, 4'h1: begin
                        bus_addr_n = ROM_DATA;
                        read_b_n   = opcode[0];
                        state_n    = S_READ_0;
                    end
                    4'h2, 4'h3: begin
                        bus_addr_n = ROM_DATA;
                        bus_we_n   = 1'b1;
                        wdata_n    = opcode[0] ? b : a;
                        state_n    = S_WRITE;
                    end
                    4'h6: if (alu_res[0]) pc_n = ROM_DATA;
                    4'h7: pc_n = ROM_DATA;
                    4'h9: begin
                        ret_n = pc + 8'd2;
                        pc_n  = ROM_DATA;
                    end
                    default: ;
                endcase
            end
            S_READ_0: state_n = S_READ_1;
            S_READ_1: state_n = S_READ_2;
            S_READ_2: begin
                if (read_b) b_n = BUS_DATA;
                else        a_n = BUS_DATA;
                state_n = S_FETCH;
            end
            S_WRITE:     state_n = S_FETCH;
            S_INT_WAIT:  state_n = S_INT_LATCH;
            S_INT_LATCH: begin
                pc_n    = ROM_DATA;
                state_n = S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_alu_cpu.sv
// Scoreboard bench for alu_cpu: small programs in a ROM model, a RAM model on
// the shared bus, expected bus writes and interrupt ACKs queued per program.
`timescale 1ns/1ps

module tb_alu_cpu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    wire  [7:0] bus_data;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic [7:0] rom_address;
    logic [7:0] rom_data = 8'h00;
    logic [1:0] irq_raise = 2'b00;
    logic [1:0] irq_ack;

    logic [7:0] rom [256];
    logic [7:0] ram [256];
    logic [15:0] exp_wr [$];
    logic [1:0]  exp_ack [$];
    logic        mon_en = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    alu_cpu dut (
        .CLK                  (clk),
        .RESET                (rst_n),
        .BUS_DATA             (bus_data),
        .BUS_ADDR             (bus_addr),
        .BUS_WE               (bus_we),
        .ROM_ADDRESS          (rom_address),
        .ROM_DATA             (rom_data),
        .BUS_INTERRUPTS_RAISE (irq_raise),
        .BUS_INTERRUPTS_ACK   (irq_ack)
    );

    // Synchronous ROM and bus-side RAM models.
    always @(posedge clk) rom_data <= rom[rom_address];
    always @(posedge clk) if (bus_we && rst_n) ram[bus_addr] <= bus_data;
    assign bus_data = bus_we ? 8'hzz : ram[bus_addr];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Scoreboard: every bus write must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (mon_en && rst_n && bus_we) begin
            check("wr_expected", 16'(exp_wr.size() != 0), 16'd1);
            if (exp_wr.size() != 0) begin
                logic [15:0] e;
                e = exp_wr.pop_front();
                check("wr_addr", 16'(bus_addr), 16'(e[15:8]));
                check("wr_data", 16'(bus_data), 16'(e[7:0]));
            end
        end
    end

    // Scoreboard: every ACK pulse must match the head of the expected-ACK queue.
    always @(negedge clk) begin
        if (mon_en && rst_n && irq_ack != 2'b00) begin
            check("ack_expected", 16'(exp_ack.size() != 0), 16'd1);
            if (exp_ack.size() != 0) check("ack_value", 16'(irq_ack), 16'(exp_ack.pop_front()));
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h08;
    endtask

    task automatic restart();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #20;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic wait_drain(input int maxc);
        for (int i = 0; i < maxc && (exp_wr.size() != 0 || exp_ack.size() != 0); i++) @(posedge clk);
        check("drain", 16'(exp_wr.size() + exp_ack.size()), 16'd0);
    endtask

    task automatic wait_ack(input logic [1:0] val, input int maxc);
        int i;
        for (i = 0; i < maxc && irq_ack != val; i++) @(negedge clk);
        check("ack_seen", 16'(irq_ack), 16'(val));
    endtask

    task automatic wait_rom_leave(input logic [7:0] from, input logic [7:0] to, input int maxc);
        for (int i = 0; i < maxc && rom_address == from; i++) @(negedge clk);
        check("isr_fetch", 16'(rom_address), 16'(to));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[8'hFF] = 8'h5A;
        ram[8'h0F] = 8'hE5;
        ram[8'h10] = 8'h1B;
        ram[8'h02] = 8'h77;
        ram[8'h00] = 8'h3C;

        // Program A: loads, every ALU op class, stores, call/return, indirect loads.
        clear_rom();
        begin
            logic [7:0] pa [60];
            pa = '{8'h00,8'h0F, 8'h01,8'h10, 8'h04, 8'h02,8'h20, 8'h14, 8'h02,8'h21,
                   8'h24, 8'h02,8'h22, 8'h35, 8'h03,8'h23, 8'h44, 8'h02,8'h24, 8'h54,
                   8'h65, 8'h74, 8'h85, 8'h03,8'h25, 8'h02,8'h26, 8'hB4, 8'h02,8'h27,
                   8'hA5, 8'h03,8'h28, 8'h96,8'h40, 8'h77,8'h30, 8'h08, 8'h08, 8'h08,
                   8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h99,8'h50,
                   8'h02,8'h29, 8'h0B, 8'h02,8'h2A, 8'h0C, 8'h03,8'h2B, 8'h0D, 8'h08};
            for (int i = 0; i < 60; i++) rom[i] = pa[i];
        end
        rom[8'h50] = 8'h54;
        rom[8'h51] = 8'h0A;

        // Reset state with the bus released (bench drives ram[FF] onto it).
        rst_n = 1'b0;
        #50;
        check("rst_rom_addr", 16'(rom_address), 16'h00);
        check("rst_bus_we",   16'(bus_we),      16'h0);
        check("rst_ack",      16'(irq_ack),     16'h0);
        check("rst_bus_addr", 16'(bus_addr),    16'hFF);
        check("rst_bus_rel",  16'(bus_data),    16'h5A);
        exp_wr = '{16'h2000, 16'h21E5, 16'h2227, 16'h234E, 16'h2413, 16'h254E,
                   16'h2613, 16'h2701, 16'h2800, 16'h2902, 16'h2A77, 16'h2B3C};
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        check("first_fetch", 16'(rom_address), 16'h00);
        for (int i = 0; i < 40 && bus_addr != 8'h0F; i++) @(negedge clk);
        check("first_read_addr", 16'(bus_addr), 16'h0F);
        wait_drain(3000);
        repeat (60) @(posedge clk);

        // Program B: taken branch to FF, operand fetch and next fetch wrap to 00.
        clear_rom();
        ram[8'h0F] = 8'h05;
        rom[8'h00] = 8'h00; rom[8'h01] = 8'h0F; rom[8'h02] = 8'h01; rom[8'h03] = 8'h0F;
        rom[8'h04] = 8'h96; rom[8'h05] = 8'hFF; rom[8'h06] = 8'h02; rom[8'h07] = 8'h31;
        rom[8'hFF] = 8'h02;
        restart();
        exp_wr = '{16'h0005, 16'h0005};
        wait_drain(1000);
        mon_en = 1'b0;

        // Program C: both interrupts raised while idle; line 0 first, then line 1.
        clear_rom();
        rom[8'h01] = 8'h02; rom[8'h02] = 8'hE2;
        rom[8'h40] = 8'h54; rom[8'h41] = 8'h02; rom[8'h42] = 8'hE0; rom[8'h43] = 8'h0A;
        rom[8'h60] = 8'h65; rom[8'h61] = 8'h03; rom[8'h62] = 8'hE1; rom[8'h63] = 8'h0A;
        rom[8'hFF] = 8'h40; rom[8'hFE] = 8'h60;
        restart();
        repeat (30) @(negedge clk);
        check("idle_no_write", 16'(bus_we), 16'h0);
        exp_ack = '{2'b01, 2'b10};
        exp_wr  = '{16'hE001, 16'hE101, 16'hE201};
        irq_raise = 2'b11;
        wait_ack(2'b01, 40);
        check("vec0_addr", 16'(rom_address), 16'hFF);
        irq_raise[0] = 1'b0;
        @(negedge clk);
        check("ack0_pulse", 16'(irq_ack), 16'h0);
        wait_rom_leave(8'hFF, 8'h40, 20);
        wait_ack(2'b10, 100);
        check("vec1_addr", 16'(rom_address), 16'hFE);
        irq_raise[1] = 1'b0;
        wait_rom_leave(8'hFE, 8'h60, 20);
        wait_drain(1000);
        repeat (60) @(posedge clk);

        // Program D: reset during the write cycle must abort the write.
        clear_rom();
        rom[8'h00] = 8'h02; rom[8'h01] = 8'h20;
        ram[8'h20] = 8'hAA;
        restart();
        mon_en = 1'b0;
        begin
            int i;
            for (i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (bus_we) break;
            end
            check("mid_write_seen", 16'(bus_we), 16'h1);
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_we",   16'(bus_we),   16'h0);
        check("mid_rst_addr", 16'(bus_addr), 16'hFF);
        check("mid_rst_rel",  16'(bus_data), 16'h5A);
        @(posedge clk); #1;
        check("mid_rst_ram",  16'(ram[8'h20]), 16'hAA);
        exp_wr = '{16'h2000};
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        wait_drain(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
